// File: rtl/halt_mem_dumper_pkg.sv
// Shared definitions for the post-halt memory dumper: FSM state
// encodings, transfer sizes and the index-counter width helper.
package halt_mem_dumper_pkg;

    // Dump FSM state encodings (3-bit, legacy-compatible constants)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_CAP   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // One streamed item is a doubleword built from two 32-bit SRAM words
    localparam int DWORD_BYTES = 8;
    localparam int WORD_BYTES  = 4;

    // Index counter width: enough to hold 0..count; at least one bit so
    // that a zero-length dump still elaborates.
    function automatic int idx_width(input int count);
        return (count < 1) ? 1 : $clog2(count + 1);
    endfunction

endpackage

// File: rtl/halt_mem_dumper.sv
// Post-halt memory dumper. Once the core halts, this block owns the data
// SRAM port, reads COUNT little-endian doublewords starting at BASE_ADDR
// (two synchronous 32-bit reads each) and streams them to the debug sink.
//
// Stream handshake: dout_valid is raised in OUT and held, together with
// dout_data/dout_addr/dout_last, until a rising edge where dout_ready is
// also high; that edge is the transfer. dout_ready is ignored whenever
// dout_valid is low, and valid never depends combinationally on ready.
module halt_mem_dumper
    import halt_mem_dumper_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                COUNT     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    input  logic [31:0]       mem_rdata,
    output logic              dump_active,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [63:0]       dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_last,
    output logic              done
);

    localparam int                IDX_W      = idx_width(COUNT);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'((COUNT > 0) ? COUNT - 1 : 0);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] DWORD_STEP = ADDR_W'(DWORD_BYTES);
    localparam logic              HAS_ITEMS  = (COUNT > 0);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [IDX_W-1:0]  index;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       lo_word;
    logic [31:0]       hi_word;
    logic              is_last;

    assign is_last = (index == LAST_IDX);

    // Next-state logic: one item walks RD_LO -> RD_HI -> CAP -> OUT
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (halt) state_nxt = HAS_ITEMS ? ST_RD_LO : ST_DONE;
            ST_RD_LO: state_nxt = ST_RD_HI;
            ST_RD_HI: state_nxt = ST_CAP;
            ST_CAP:   state_nxt = ST_OUT;
            ST_OUT:   if (dout_ready) state_nxt = is_last ? ST_DONE : ST_RD_LO;
            ST_DONE:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, address and capture registers; mem_addr only moves when a new
    // read is issued so it holds still during stalls and after DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            index    <= '0;
            cur_addr <= '0;
            mem_addr <= '0;
            lo_word  <= '0;
            hi_word  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (halt && HAS_ITEMS) begin
                        cur_addr <= BASE_ADDR;
                        mem_addr <= BASE_ADDR;
                    end
                end
                ST_RD_LO: mem_addr <= cur_addr + WORD_STEP;
                ST_RD_HI: lo_word  <= mem_rdata;
                ST_CAP:   hi_word  <= mem_rdata;
                ST_OUT: begin
                    if (dout_ready && !is_last) begin
                        index    <= index + IDX_W'(1);
                        cur_addr <= cur_addr + DWORD_STEP;
                        mem_addr <= cur_addr + DWORD_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: port ownership and stream qualifiers follow the state
    always_comb begin
        mem_w_en    = 4'b0000;
        dump_active = (state == ST_RD_LO) || (state == ST_RD_HI) ||
                      (state == ST_CAP)   || (state == ST_OUT);
        dout_valid  = (state == ST_OUT);
        dout_last   = (state == ST_OUT) && is_last;
        done        = (state == ST_DONE);
        dout_data   = {hi_word, lo_word};
        dout_addr   = cur_addr;
    end

endmodule
